// File: rtl/display_pkg.sv
// Shared types and constants for the scanned 8-digit seven-segment display.
// The segment table is active-low with bit 0 = segment a through bit 6 = segment g.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  BLANK_SEG  = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Converts a 16-bit value to decimal (double-dabble) or hex digits and scans them
// across an 8-digit multiplexed seven-segment display.
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        hex_mode,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        dp,
    output logic        busy
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

    state_t                          state_q, state_d;
    logic [15:0]                     last_val_q, last_val_d;
    logic                            last_mode_q, last_mode_d;
    logic [15:0]                     shift_q, shift_d;
    logic [19:0]                     bcd_q, bcd_d;
    logic [3:0]                      bit_q, bit_d;
    logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_d;
    logic [NUM_DIGITS-1:0]           blank_q, blank_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [2:0]                      idx_q, idx_d;
    logic [6:0]                      seg_q, seg_d;
    logic [7:0]                      an_q, an_d;
    logic                            busy_q, busy_d;

    logic [19:0]                     adj;
    logic [35:0]                     dd;
    logic                            seen;
    logic [6:0]                      dec_seg;

    seg7_decoder u_dec (
        .nibble_i (dig_d[idx_d]),
        .seg_o    (dec_seg)
    );

    always_comb begin
        state_d     = state_q;
        last_val_d  = last_val_q;
        last_mode_d = last_mode_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        bit_d       = bit_q;
        dig_d       = dig_q;
        blank_d     = blank_q;
        adj         = '0;
        dd          = '0;
        seen        = 1'b0;

        case (state_q)
            IDLE: begin
                if (value_in != last_val_q || hex_mode != last_mode_q) begin
                    state_d     = CONV;
                    shift_d     = value_in;
                    bcd_d       = '0;
                    bit_d       = '0;
                    last_val_d  = value_in;
                    last_mode_d = hex_mode;
                end
            end
            CONV: begin
                for (int unsigned k = 0; k < 5; k++) begin
                    adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? 4'(bcd_q[4*k +: 4] + 4'd3)
                                                               : bcd_q[4*k +: 4];
                end
                dd      = {adj, shift_q} << 1;
                bcd_d   = dd[35:16];
                shift_d = dd[15:0];
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'd15) state_d = DONE;
            end
            DONE: begin
                dig_d   = '0;
                blank_d = '1;
                if (last_mode_q) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        dig_d[k]   = last_val_q[4*k +: 4];
                        blank_d[k] = 1'b0;
                    end
                end else begin
                    for (int unsigned k = 0; k < 5; k++) dig_d[k] = bcd_q[4*k +: 4];
                    blank_d[0] = 1'b0;
                    // Walk from the most significant decimal digit down; a digit
                    // stays blank until the first non-zero one is seen.
                    for (int unsigned k = 0; k < 4; k++) begin
                        seen           = seen | (bcd_q[4*(4-k) +: 4] != 4'd0);
                        blank_d[4-k]   = ~seen;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        if (cnt_q == TERM) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end

        // Outputs are computed from next-state index and digits so seg/an
        // always match the registered scan position on the same edge.
        an_d  = ~(8'b1 << idx_d);
        seg_d = blank_d[idx_d] ? BLANK_SEG : dec_seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_val_q  <= '0;
            last_mode_q <= 1'b0;
            shift_q     <= '0;
            bcd_q       <= '0;
            bit_q       <= '0;
            dig_q       <= '0;
            blank_q     <= 8'hFE;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_TABLE[0];
            an_q        <= 8'hFE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_val_q  <= last_val_d;
            last_mode_q <= last_mode_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            bit_q       <= bit_d;
            dig_q       <= dig_d;
            blank_q     <= blank_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            busy_q      <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized self-checking bench for bcd_scan_display with a value-level display model.
module tb_bcd_scan_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic        hex_mode = 1'b0;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic        busy;

    int nchecks = 0;
    int nerrors = 0;
    int ncyc    = 0;

    logic [6:0] pat [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    bcd_scan_display #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .hex_mode (hex_mode),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset; the scan position follows from it directly.
    always @(posedge clk) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    function automatic int cur_idx();
        return (ncyc / RD) % 8;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input bit m, input int d);
        int p;
        if (m) return (d < 4) ? pat[(v >> (4 * d)) & 15] : 7'h7F;
        if (d > 4) return 7'h7F;
        p = 10 ** d;
        if (d != 0 && v < p) return 7'h7F;
        return pat[(v / p) % 10];
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs already applied; counts busy samples of the conversion that follows.
    task automatic wait_conv(output int len);
        len = 0;
        @(negedge clk);
        while (busy && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic scan_check(input int v, input bit m);
        for (int i = 0; i < 8 * RD + 1; i++) begin
            check("an", an, ~(8'b1 << cur_idx()) & 8'hFF);
            check("seg", seg, exp_seg(v, m, cur_idx()));
            check("dp", dp, 1);
            @(negedge clk);
        end
    endtask

    task automatic convert(input int v, input bit m);
        int len;
        value_in = 16'(v);
        hex_mode = m;
        wait_conv(len);
        check("busy_len", len, 17);
        scan_check(v, m);
    endtask

    initial begin
        int len;
        int v;
        bit m;
        int last_v;
        bit last_m;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 7'h40);
        check("rst_busy", busy, 0);
        check("rst_dp", dp, 1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end
        scan_check(0, 0);

        convert(65535, 0);
        convert(16'hBEEF, 1);
        convert(7, 0);

        // Input changes mid-conversion: old value completes, then new one follows.
        value_in = 16'd100;
        hex_mode = 1'b0;
        len = 0;
        @(negedge clk);
        while (busy && len < 40) begin
            len++;
            if (len == 5) value_in = 16'd200;
            @(negedge clk);
        end
        check("busy_len_100", len, 17);
        check("seg_100", seg, exp_seg(100, 0, cur_idx()));
        len = 0;
        @(negedge clk);
        while (busy && len < 40) begin
            len++;
            check("seg_hold_100", seg, exp_seg(100, 0, cur_idx()));
            @(negedge clk);
        end
        check("busy_len_200", len, 17);
        scan_check(200, 0);

        // Reset during conversion aborts it; release restarts from cleared state.
        value_in = 16'd4321;
        len = 0;
        @(negedge clk);
        while (busy && len < 8) begin
            len++;
            if (len < 8) @(negedge clk);
        end
        check("abort_reach", len, 8);
        rst = 1'b1;
        @(negedge clk);
        check("abort_an", an, 8'hFE);
        check("abort_seg", seg, 7'h40);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        wait_conv(len);
        check("restart_len", len, 17);
        scan_check(4321, 0);

        last_v = 4321;
        last_m = 1'b0;
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(0, 65535));
            m = 1'(($urandom_range(0, 1)));
            if (v == last_v && m == last_m) v = v ^ 1;
            convert(v, m);
            last_v = v;
            last_m = m;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value_in  input  16  calculator display channel, unsigned.
REQ-005 SHALL have port hex_mode  input  1  1 = hexadecimal display, 0 = decimal display.
REQ-006 SHALL have port seg  output  7  segment cathodes, active-low, seg[0]=a ... seg[6]=g.
REQ-007 SHALL have port an  output  8  digit anodes, active-low, one-hot-zero.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, constant 1 (off).
REQ-009 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-010 SHALL keep registers last_val[15:0] and last_mode, holding the value and mode of the most recent conversion start.
REQ-011 SHALL use states IDLE, CONV, DONE; IDLE -> CONV when value_in != last_val or hex_mode != last_mode, else stay in IDLE.
REQ-012 SHALL, on the IDLE->CONV edge, load value_in into a 16-bit shift register, clear the 20-bit BCD accumulator, and update last_val/last_mode.
REQ-013 SHALL perform one double-dabble iteration per CONV cycle (add 3 to every BCD nibble >= 5, then shift left 1), exactly 16 cycles, then go to DONE.
REQ-014 SHALL, in DONE, commit all eight display digits and blank flags atomically to the display register, then return to IDLE.
REQ-015 SHALL assert busy in CONV and DONE only: exactly 17 cycles per conversion; new digits are visible from the 18th edge after the start edge.
REQ-016 SHALL ignore value_in/hex_mode changes during CONV/DONE; the IDLE compare then restarts conversion, so the display never shows mixed old/new digits.
REQ-017 SHALL, in hex mode, show value_in nibbles [3:0]..[15:12] on digits 0..3, all shown (no blanking), with digits 4..7 blank.
REQ-018 SHALL, in decimal mode, show BCD units..ten-thousands on digits 0..4, blank leading zeros above digit 0 (digit 0 always lit), and blank digits 5..7.
REQ-019 SHALL take the hex-mode digits from the same DONE commit, so the mode switch latency equals the conversion latency.
REQ-020 SHALL run a refresh counter 0..REFRESH_DIV-1; at the terminal count it wraps to 0 and the digit index increments, with 7 wrapping to 0.
REQ-021 SHALL drive an low only at bit [index] and seg = decode(display digit[index]); a blank digit gives seg = 7'h7F.
REQ-022 SHALL register seg and an so they change on the same edge, with no glitch between digits.
REQ-023 SHALL decode 0-F to standard patterns, e.g. 0=7'h40, 5=7'h12, B=7'h03, E=7'h06, F=7'h0E.

Reset
REQ-024 SHALL, on rst, return to IDLE and clear the refresh counter, index, last_val, last_mode, shift register, and BCD accumulator; display register SHALL become digit 0 = "0" lit, all other digits blank.
REQ-025 SHALL drive outputs after reset: an=8'hFE, seg=7'h40, dp=1, busy=0.
REQ-026 SHALL abort any conversion in progress when rst is asserted, with nothing committed.
REQ-027 SHALL, after reset release, start a conversion on the first edge if value_in != 0 or hex_mode = 1.

Structure
REQ-028 SHALL place the state enum typedef, NUM_DIGITS=8, BLANK_SEG=7'h7F and the 16-entry segment pattern table in shared package display_pkg.
REQ-029 SHALL implement the nibble-to-segment decode as combinational sub-module seg7_decoder, one instance.

Verification
REQ-030 SHALL verify: rst high 2 cycles, value_in=0, hex_mode=0 -> an=8'hFE, seg=7'h40, busy=0, no conversion starts.
REQ-031 SHALL verify: REFRESH_DIV=4, steady input -> an steps FE,FD,FB,F7,EF,DF,BF,7F,FE, each held 4 cycles.
REQ-032 SHALL verify: value_in=16'd65535, decimal -> busy high 17 cycles; digits 4..0 = 6,5,5,3,5; digit 0 seg=7'h12.
REQ-033 SHALL verify: value_in=16'hBEEF, hex_mode=1 -> digits 3..0 = B,E,E,F (seg 03,06,06,0E); digits 4..7 seg=7'h7F.
REQ-034 SHALL verify: value_in=16'd7, decimal -> only digit 0 lit (7'h78); digits 1..7 seg=7'h7F.
REQ-035 SHALL verify: value_in 100 -> 200 on the 5th CONV cycle -> display shows 100 after 17 busy cycles, then a second 17-cycle conversion shows 200, with no intermediate value; rst on the 8th CONV cycle -> reset state of REQ-025.
